// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg
//   Shared definitions for the dual-port RAM arbiter: master IDs, the
//   per-channel arbitration state encoding and small helpers.
//   No ports.
package ram_port_arbiter_pkg;

    localparam logic M0_ID = 1'b0;  // core load/store unit
    localparam logic M1_ID = 1'b1;  // debug/loader

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_e;

    function automatic logic other_master(input logic id);
        return ~id;
    endfunction

    function automatic arb_state_e lock_state(input logic id);
        return id ? ST_LOCK1 : ST_LOCK0;
    endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
//   One requester's write and read channels towards the RAM arbiter.
//   master modport: requester side (drives wen/waddr/wdata/wlock, ren/raddr/rlock)
//   slave  modport: arbiter side  (drives wready, rready, rvalid, rdata)
interface ram_port_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 12
) ();
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wlock;
    logic          wready;
    logic          ren;
    logic [AW-1:0] raddr;
    logic          rlock;
    logic          rready;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output wen, waddr, wdata, wlock, ren, raddr, rlock,
        input  wready, rready, rvalid, rdata
    );

    modport slave (
        input  wen, waddr, wdata, wlock, ren, raddr, rlock,
        output wready, rready, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arb2_lock.sv
// rr_arb2_lock
//   Two-way round-robin arbiter with burst lock and idle-timeout release.
//   Ports:
//     clk, rst   clock, async active-high reset
//     req_i[1:0] request per master
//     lock_i[1:0] keep the grant after this transfer
//     ready_o[1:0] transfer accepted this cycle (grant && request)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_ARB   | open arbitration, ptr_q picks the winner on contention
//   ST_LOCK0 | M0 owns the channel, M1 held off
//   ST_LOCK1 | M1 owns the channel, M0 held off
module rr_arb2_lock
    import ram_port_arbiter_pkg::*;
#(
    parameter int LOCK_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] ready_o
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(LOCK_MAX - 1);

    arb_state_e    state_q;
    logic          ptr_q;
    logic [CW-1:0] idle_q;
    logic [1:0]    gnt;
    logic          winner;
    logic          accepted;
    logic          lock_owner;

    always_comb begin
        gnt = 2'b00;
        case (state_q)
            ST_LOCK0: gnt = 2'b01;
            ST_LOCK1: gnt = 2'b10;
            default: begin
                if (req_i == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
                else                gnt = req_i;
            end
        endcase
    end

    assign ready_o    = gnt & req_i;
    assign accepted   = |ready_o;
    assign winner     = ready_o[1];
    assign lock_owner = (state_q == ST_LOCK1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ARB;
            ptr_q   <= M0_ID;
            idle_q  <= '0;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (accepted) begin
                        ptr_q  <= other_master(winner);
                        idle_q <= '0;
                        if (lock_i[winner]) state_q <= lock_state(winner);
                    end
                end
                ST_LOCK0, ST_LOCK1: begin
                    if (accepted) begin
                        ptr_q  <= other_master(lock_owner);
                        idle_q <= '0;
                        if (!lock_i[lock_owner]) state_q <= ST_ARB;
                    end else if (idle_q == IDLE_LAST) begin
                        // owner went quiet too long: hand the channel back
                        state_q <= ST_ARB;
                        ptr_q   <= other_master(lock_owner);
                        idle_q  <= '0;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares the write and read ports of dual_ram between M0 (LSU) and M1
//   (debug/loader). Channels are arbitrated independently; read data comes
//   back one cycle after acceptance and is steered to the owner.
//   Ports:
//     clk, rst             clock, async active-high reset
//     m0, m1               requester channels (slave modport)
//     ram_w_en_o/addr/data write port to dual_ram, zero latency
//     ram_r_en_o/addr      read port to dual_ram, zero latency
//     ram_r_data_i         dual_ram read data, valid cycle after ram_r_en_o
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 12,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    ram_port_arbiter_if.slave m0,
    ram_port_arbiter_if.slave m1,
    output logic              ram_w_en_o,
    output logic [AW-1:0]     ram_w_addr_o,
    output logic [DW-1:0]     ram_w_data_o,
    output logic              ram_r_en_o,
    output logic [AW-1:0]     ram_r_addr_o,
    input  logic [DW-1:0]     ram_r_data_i
);
    logic [1:0] w_ready;
    logic [1:0] r_ready;
    logic       rtag_vld_q, rtag_vld_d;
    logic       rtag_own_q, rtag_own_d;

    rr_arb2_lock #(.LOCK_MAX(LOCK_MAX)) u_w_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({m1.wen, m0.wen}),
        .lock_i  ({m1.wlock, m0.wlock}),
        .ready_o (w_ready)
    );

    rr_arb2_lock #(.LOCK_MAX(LOCK_MAX)) u_r_arb (
        .clk     (clk),
        .rst     (rst),
        .req_i   ({m1.ren, m0.ren}),
        .lock_i  ({m1.rlock, m0.rlock}),
        .ready_o (r_ready)
    );

    assign m0.wready = w_ready[0];
    assign m1.wready = w_ready[1];
    assign m0.rready = r_ready[0];
    assign m1.rready = r_ready[1];

    assign ram_w_en_o   = |w_ready;
    assign ram_w_addr_o = w_ready[1] ? m1.waddr : (w_ready[0] ? m0.waddr : '0);
    assign ram_w_data_o = w_ready[1] ? m1.wdata : (w_ready[0] ? m0.wdata : '0);
    assign ram_r_en_o   = |r_ready;
    assign ram_r_addr_o = r_ready[1] ? m1.raddr : (r_ready[0] ? m0.raddr : '0);

    // tag follows the accepted read so the returning word goes to its owner
    assign rtag_vld_d = |r_ready;
    assign rtag_own_d = r_ready[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtag_vld_q <= 1'b0;
            rtag_own_q <= M0_ID;
        end else begin
            rtag_vld_q <= rtag_vld_d;
            rtag_own_q <= rtag_own_d;
        end
    end

    assign m0.rvalid = rtag_vld_q && (rtag_own_q == M0_ID);
    assign m1.rvalid = rtag_vld_q && (rtag_own_q == M1_ID);
    assign m0.rdata  = m0.rvalid ? ram_r_data_i : '0;
    assign m1.rdata  = m1.rvalid ? ram_r_data_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
module tb_ram_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int LOCK_MAX = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.DW(DW), .AW(AW)) m0_if ();
    ram_port_arbiter_if #(.DW(DW), .AW(AW)) m1_if ();

    logic          ram_w_en, ram_r_en;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [DW-1:0] ram_w_data;
    logic [DW-1:0] ram_r_data = '0;

    ram_port_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .m0           (m0_if),
        .m1           (m1_if),
        .ram_w_en_o   (ram_w_en),
        .ram_w_addr_o (ram_w_addr),
        .ram_w_data_o (ram_w_data),
        .ram_r_en_o   (ram_r_en),
        .ram_r_addr_o (ram_r_addr),
        .ram_r_data_i (ram_r_data)
    );

    // requester drive
    logic [1:0]    w_req = '0, w_lock = '0, r_req = '0, r_lock = '0;
    logic [AW-1:0] w_addr [2];
    logic [DW-1:0] w_data [2];
    logic [AW-1:0] r_addr [2];

    assign m0_if.wen = w_req[0];   assign m1_if.wen = w_req[1];
    assign m0_if.wlock = w_lock[0]; assign m1_if.wlock = w_lock[1];
    assign m0_if.waddr = w_addr[0]; assign m1_if.waddr = w_addr[1];
    assign m0_if.wdata = w_data[0]; assign m1_if.wdata = w_data[1];
    assign m0_if.ren = r_req[0];   assign m1_if.ren = r_req[1];
    assign m0_if.rlock = r_lock[0]; assign m1_if.rlock = r_lock[1];
    assign m0_if.raddr = r_addr[0]; assign m1_if.raddr = r_addr[1];

    // dual_ram stand-in: registered read with write bypass
    logic [DW-1:0] ram_mem [1<<AW];
    always @(posedge clk) begin
        if (ram_r_en)
            ram_r_data <= (ram_w_en && ram_w_addr == ram_r_addr) ? ram_w_data : ram_mem[ram_r_addr];
        if (ram_w_en) ram_mem[ram_w_addr] <= ram_w_data;
    end

    function automatic logic [DW-1:0] init_word(input int i);
        return 32'hC0DE0000 + i * 3;
    endfunction

    // reference model: channel 0 = write, 1 = read
    logic [DW-1:0] ref_mem [1<<AW];
    int lk [2];     // locked owner, -1 when open
    int pref [2];   // preferred master on contention
    int idl [2];    // idle cycles while locked
    logic [1:0]    exp_rv;
    logic [DW-1:0] exp_rd [2];

    int n_assert = 0;
    int n_fail = 0;

    // last sampled DUT values
    logic [1:0]    dut_w, dut_r, dut_rv;
    logic [DW-1:0] dut_rd [2];
    logic [1:0]    acc_w, acc_r;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            lk[c] = -1; pref[c] = 0; idl[c] = 0;
            exp_rd[c] = '0;
        end
        exp_rv = 2'b00;
    endfunction

    function automatic logic [1:0] predict(input int ch, input logic [1:0] req);
        logic [1:0] g;
        if (lk[ch] >= 0) g = req & (lk[ch] == 1 ? 2'b10 : 2'b01);
        else if (req == 2'b11) g = (pref[ch] == 1) ? 2'b10 : 2'b01;
        else g = req;
        return g;
    endfunction

    function automatic void update(input int ch, input logic [1:0] acc, input logic [1:0] lock);
        int w;
        if (acc != 2'b00) begin
            w = acc[1] ? 1 : 0;
            pref[ch] = 1 - w;
            idl[ch] = 0;
            lk[ch] = lock[w] ? w : -1;
        end else if (lk[ch] >= 0) begin
            idl[ch]++;
            if (idl[ch] == LOCK_MAX) begin
                pref[ch] = 1 - lk[ch];
                lk[ch] = -1;
                idl[ch] = 0;
            end
        end
    endfunction

    // one clock: sample at negedge against model, then advance the model
    task automatic step();
        logic [1:0] ew, er;
        @(negedge clk);
        ew = predict(0, w_req);
        er = predict(1, r_req);
        dut_w = {m1_if.wready, m0_if.wready};
        dut_r = {m1_if.rready, m0_if.rready};
        dut_rv = {m1_if.rvalid, m0_if.rvalid};
        dut_rd[0] = m0_if.rdata;
        dut_rd[1] = m1_if.rdata;
        n_assert++;
        if (dut_w !== ew) begin n_fail++; $display("FAIL wready: got %b want %b @%0t", dut_w, ew, $time); end
        n_assert++;
        if (dut_r !== er) begin n_fail++; $display("FAIL rready: got %b want %b @%0t", dut_r, er, $time); end
        n_assert++;
        if (dut_rv !== exp_rv) begin n_fail++; $display("FAIL rvalid: got %b want %b @%0t", dut_rv, exp_rv, $time); end
        for (int m = 0; m < 2; m++) begin
            n_assert++;
            if (dut_rd[m] !== exp_rd[m]) begin
                n_fail++; $display("FAIL m%0d_rdata: got %h want %h @%0t", m, dut_rd[m], exp_rd[m], $time);
            end
        end
        n_assert++;
        if (ram_w_en !== (|ew)) begin n_fail++; $display("FAIL ram_w_en: got %b want %b @%0t", ram_w_en, |ew, $time); end
        if (|ew) begin
            n_assert++;
            if (ram_w_addr !== w_addr[ew[1]] || ram_w_data !== w_data[ew[1]]) begin
                n_fail++;
                $display("FAIL ram_w_bus: got %h/%h want %h/%h @%0t", ram_w_addr, ram_w_data, w_addr[ew[1]], w_data[ew[1]], $time);
            end
        end
        n_assert++;
        if (ram_r_en !== (|er)) begin n_fail++; $display("FAIL ram_r_en: got %b want %b @%0t", ram_r_en, |er, $time); end
        if (|er) begin
            n_assert++;
            if (ram_r_addr !== r_addr[er[1]]) begin
                n_fail++; $display("FAIL ram_r_addr: got %h want %h @%0t", ram_r_addr, r_addr[er[1]], $time);
            end
        end
        @(posedge clk);
        if (|ew) ref_mem[w_addr[ew[1]]] = w_data[ew[1]];
        exp_rv = er;
        for (int m = 0; m < 2; m++) exp_rd[m] = er[m] ? ref_mem[r_addr[m]] : '0;
        update(0, ew, w_lock);
        update(1, er, r_lock);
        acc_w = ew;
        acc_r = er;
        #1;
    endtask

    task automatic clear_reqs();
        w_req = '0; w_lock = '0; r_req = '0; r_lock = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_reqs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_assert++;
        if ({m1_if.wready, m0_if.wready, m1_if.rready, m0_if.rready} !== 4'b0) begin
            n_fail++; $display("FAIL reset_ready: got %b%b%b%b want 0000", m1_if.wready, m0_if.wready, m1_if.rready, m0_if.rready);
        end
        n_assert++;
        if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00) begin
            n_fail++; $display("FAIL reset_rvalid: got %b want 00", {m1_if.rvalid, m0_if.rvalid});
        end
        n_assert++;
        if (m0_if.rdata !== '0 || m1_if.rdata !== '0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", m0_if.rdata, m1_if.rdata);
        end
        n_assert++;
        if ({ram_w_en, ram_r_en} !== 2'b00) begin
            n_fail++; $display("FAIL reset_ram_en: got %b want 00", {ram_w_en, ram_r_en});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_alternating_reads();
        logic [1:0] prev;
        do_reset();
        r_addr[0] = 12'h010; r_addr[1] = 12'h020;
        r_req = 2'b11; r_lock = 2'b00;
        prev = 2'b00;
        for (int i = 0; i < 8; i++) begin
            step();
            n_assert++;
            if (dut_r !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL alt_grant[%0d]: got %b want %b", i, dut_r, (i % 2 == 0) ? 2'b01 : 2'b10);
            end
            if (i > 0) begin
                n_assert++;
                if (dut_rv !== prev || dut_rd[prev[1]] !== init_word(prev[1] ? 'h020 : 'h010)) begin
                    n_fail++; $display("FAIL alt_rdata[%0d]: got rv %b data %h want rv %b data %h", i, dut_rv, dut_rd[prev[1]], prev, init_word(prev[1] ? 'h020 : 'h010));
                end
            end
            prev = dut_r;
        end
        r_req = 2'b00;
        step();
    endtask

    task automatic test_write_lock();
        w_req = 2'b01; w_addr[0] = 12'h0FF; w_data[0] = 32'h11111111; w_lock = 2'b00;
        step();
        w_addr[0] = 12'h200; w_data[0] = 32'h22222222;
        for (int k = 0; k < 4; k++) begin
            w_req = 2'b11;
            w_addr[1] = 12'h100 + 12'(k);
            w_data[1] = $urandom;
            w_lock = {(k < 3) ? 1'b1 : 1'b0, 1'b0};
            step();
            n_assert++;
            if (dut_w !== 2'b10) begin n_fail++; $display("FAIL wlock_burst[%0d]: got %b want 10", k, dut_w); end
        end
        w_req = 2'b01; w_lock = 2'b00;
        step();
        n_assert++;
        if (dut_w !== 2'b01) begin n_fail++; $display("FAIL wlock_m0_after: got %b want 01", dut_w); end
        w_req = 2'b00;
    endtask

    task automatic test_lock_timeout();
        int n;
        bit granted;
        r_req = 2'b10; r_addr[1] = 12'h030; r_lock = 2'b10;
        step();
        r_req = 2'b01; r_addr[0] = 12'h050; r_lock = 2'b00;
        n = 0; granted = 0;
        while (!granted && n < 40) begin
            step();
            n++;
            if (dut_r[0] === 1'b1) granted = 1;
        end
        n_assert++;
        if (!granted || n != LOCK_MAX + 1) begin
            n_fail++; $display("FAIL lock_timeout: granted %0d after %0d cycles want 1 after %0d", granted, n, LOCK_MAX + 1);
        end
        r_req = 2'b00;
        step();
    endtask

    task automatic test_rw_same_cycle();
        w_req = 2'b01; w_addr[0] = 12'h040; w_data[0] = 32'hDEADBEEF; w_lock = 2'b00;
        r_req = 2'b10; r_addr[1] = 12'h040; r_lock = 2'b00;
        step();
        n_assert++;
        if (dut_w !== 2'b01 || dut_r !== 2'b10) begin
            n_fail++; $display("FAIL rw_accept: got w %b r %b want w 01 r 10", dut_w, dut_r);
        end
        clear_reqs();
        step();
        n_assert++;
        if (dut_rv !== 2'b10 || dut_rd[1] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL rw_bypass: got rv %b data %h want rv 10 data deadbeef", dut_rv, dut_rd[1]);
        end
    endtask

    task automatic test_reset_midread();
        r_req = 2'b01; r_addr[0] = 12'h010; r_lock = 2'b00;
        step();
        rst = 1'b1;
        clear_reqs();
        model_reset();
        @(negedge clk);
        n_assert++;
        if ({m1_if.rvalid, m0_if.rvalid} !== 2'b00 || m0_if.rdata !== '0) begin
            n_fail++; $display("FAIL midread_rst: got rv %b data %h want rv 00 data 0", {m1_if.rvalid, m0_if.rvalid}, m0_if.rdata);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step();
        w_req = 2'b11; w_addr[0] = 12'h060; w_addr[1] = 12'h061;
        w_data[0] = $urandom; w_data[1] = $urandom;
        r_req = 2'b11; r_addr[0] = 12'h062; r_addr[1] = 12'h063;
        step();
        n_assert++;
        if (dut_w !== 2'b01 || dut_r !== 2'b01) begin
            n_fail++; $display("FAIL post_rst_grant: got w %b r %b want w 01 r 01", dut_w, dut_r);
        end
        clear_reqs();
        step();
    endtask

    task automatic test_single_reader();
        int ok = 0;
        r_req = 2'b10; r_lock = 2'b00;
        for (int i = 0; i < 16; i++) begin
            r_addr[1] = 12'h300 + 12'(i);
            step();
            if (dut_r === 2'b10) ok++;
        end
        n_assert++;
        if (ok != 16) begin n_fail++; $display("FAIL single_reader: got %0d accepts want 16", ok); end
        r_req = 2'b00;
        step();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            int rate;
            rate = (cyc % 200 < 100) ? 2 : 8;
            for (int m = 0; m < 2; m++) begin
                if (!w_req[m] && $urandom_range(0, rate - 1) == 0) begin
                    w_req[m] = 1'b1;
                    w_addr[m] = 12'($urandom_range(0, 63));
                    w_data[m] = $urandom;
                    w_lock[m] = ($urandom_range(0, 3) == 0);
                end
                if (!r_req[m] && $urandom_range(0, rate - 1) == 0) begin
                    r_req[m] = 1'b1;
                    r_addr[m] = 12'($urandom_range(0, 63));
                    r_lock[m] = ($urandom_range(0, 3) == 0);
                end
            end
            step();
            for (int m = 0; m < 2; m++) begin
                if (acc_w[m]) w_req[m] = 1'b0;
                if (acc_r[m]) r_req[m] = 1'b0;
            end
        end
        clear_reqs();
        step();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        for (int m = 0; m < 2; m++) begin
            w_addr[m] = '0; w_data[m] = '0; r_addr[m] = '0;
        end
        model_reset();
        test_reset();
        test_alternating_reads();
        test_write_lock();
        test_lock_timeout();
        test_rw_same_cycle();
        test_reset_midread();
        test_single_reader();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
